// File: rtl/dbg_clk_ctrl_pkg.sv
// Shared types and constants for the debug clock controller.
package dbg_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2,
        BRK  = 2'd3
    } dbg_state_t;

    localparam int CE_CNT_W = 32;

    // Width of div_sel needed to address every prescaler bit.
    function automatic int sel_w_of(input int div_w);
        return (div_w > 1) ? $clog2(div_w) : 1;
    endfunction

endpackage

// File: rtl/dbg_clk_ctrl_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// a one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The count only runs while the synchronised input disagrees with the
    // accepted level; any agreement (a bounce) starts it over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
                press <= sync_p1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dbg_clk_ctrl.sv
// Debug clock controller: divided CPU clock enable with run, halt,
// single-step and breakpoint control driven by a debounced push button.
module dbg_clk_ctrl
    import dbg_clk_ctrl_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int SEL_W        = sel_w_of(DIV_W),
    parameter int PC_W         = 16,
    parameter int DEB_CYC      = 50000,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic                mode_step,
    input  logic                btn,
    input  logic                bp_en,
    input  logic [PC_W-1:0]     bp_addr,
    input  logic [PC_W-1:0]     pcnt,
    output logic                cpu_ce,
    output logic                halted,
    output logic                brk_hit,
    output logic [CE_CNT_W-1:0] ce_count
);

    localparam dbg_state_t RST_STATE = RUN_ON_RESET ? RUN : HALT;

    // Division is capped at 2^(DIV_W-1); larger selections saturate.
    function automatic logic [DIV_W-1:0] sat_mask(input logic [SEL_W-1:0] sel);
        logic [DIV_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIV_W - 1; i++) begin
            if (i < int'(sel)) m[i] = 1'b1;
        end
        return m;
    endfunction

    dbg_state_t       state;
    dbg_state_t       state_nxt;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] mask;
    logic             live;
    logic             tick;
    logic             bp_match;
    logic             press;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(press)
    );

    // live keeps the enable quiet until the first edge after reset release,
    // and drops asynchronously with reset so a pending step is aborted.
    assign mask     = sat_mask(div_sel);
    assign tick     = live && ((presc & mask) == mask);
    assign bp_match = bp_en && (pcnt == bp_addr);

    always_comb begin
        state_nxt = state;
        cpu_ce    = 1'b0;
        case (state)
            RUN: begin
                if (tick && bp_match) begin
                    state_nxt = BRK;
                end else begin
                    cpu_ce = tick;
                    if (mode_step) state_nxt = HALT;
                end
            end
            HALT, BRK: begin
                if (press) state_nxt = STEP;
            end
            STEP: begin
                if (tick) begin
                    cpu_ce    = 1'b1;
                    state_nxt = mode_step ? HALT : RUN;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_STATE;
            halted   <= !RUN_ON_RESET;
            brk_hit  <= 1'b0;
            live     <= 1'b0;
            presc    <= '0;
            ce_count <= '0;
        end else begin
            state   <= state_nxt;
            halted  <= (state_nxt != RUN);
            brk_hit <= (state_nxt == BRK);
            live    <= 1'b1;
            presc   <= presc + DIV_W'(1);
            if (cpu_ce) ce_count <= ce_count + CE_CNT_W'(1);
        end
    end

endmodule
